rf68000_irq_router: RTL and testbench

Distributes the single encoded interrupt request from the platform interrupt controller (level, cause, target core) to up to eight rf68000 cores. Each core gets a pending slot and a two-deep active-level stack, so delivery, acknowledge and end-of-interrupt are sequenced per core. The block sits between the interrupt controller outputs and the per-core irq inputs. Broadcast requests can optionally be spread round-robin across cores.

---
 rtl/rf68000_irq_router_if.sv | 31 +++
 rtl/rf68000_irq_router.sv | 237 +++++++++++++++++++++++
 tb/tb_rf68000_irq_router.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rf68000_irq_router_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf68000_irq_router_if
//  Description : Signal bundle between the platform interrupt controller /
//                rf68000 cores (master) and the interrupt router (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf68000_irq_router_if #(
   parameter int NCORES = 4
);
   logic [3:0]          irq_i;
   logic [7:0]          cause_i;
   logic [5:0]          core_i;
   logic [NCORES-1:0]   iack_i;
   logic [NCORES-1:0]   eoi_i;
   logic [4*NCORES-1:0] irq_o;
   logic [8*NCORES-1:0] cause_o;
   logic [NCORES-1:0]   spurious_o;
   logic [NCORES-1:0]   busy_o;

   modport master (
      output irq_i, cause_i, core_i, iack_i, eoi_i,
      input  irq_o, cause_o, spurious_o, busy_o
   );

   modport slave (
      input  irq_i, cause_i, core_i, iack_i, eoi_i,
      output irq_o, cause_o, spurious_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/rf68000_irq_router.sv
`default_nettype none
// ============================================================================
//  Module      : rf68000_irq_router
//  Description : Routes the encoded interrupt request of the platform
//                interrupt controller to up to eight rf68000 cores. Each core
//                owns one pending slot and a two-deep active-level stack that
//                sequences delivery, acknowledge and end-of-interrupt.
//                Optional macro RF68000_IRQ_ROUTER_RR_EN spreads broadcast
//                requests round-robin; without it broadcasts go to core 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf68000_irq_router #(
   parameter int         NCORES   = 4,
   parameter logic [7:0] SPURIOUS = 8'd24
) (
   input  wire logic           clk_i,
   input  wire logic           rst_i,
   rf68000_irq_router_if.slave bus
);
   localparam logic [5:0] c_BCAST  = 6'h3F;
   localparam logic [5:0] c_NCORES = 6'(NCORES);

   // Registered request tuple and the last tuple a capture was attempted with
   logic [3:0]  r_in_irq;
   logic [7:0]  r_in_cause;
   logic [5:0]  r_in_core;
   logic [17:0] r_last;
   logic [17:0] w_last;

   // Per-core pending slot and active stack. The cause of an active entry is
   // already reported on cause_o at acknowledge, so only its level is kept:
   // the level alone decides masking of lower pending requests.
   logic       r_pv     [NCORES];
   logic [3:0] r_plvl   [NCORES];
   logic [7:0] r_pcause [NCORES];
   logic [3:0] r_alvl   [NCORES][2];
   logic [1:0] r_sd     [NCORES];
   logic       w_pv     [NCORES];
   logic [3:0] w_plvl   [NCORES];
   logic [7:0] w_pcause [NCORES];
   logic [3:0] w_alvl   [NCORES][2];
   logic [1:0] w_sd     [NCORES];
   logic [3:0] w_atop   [NCORES];

   logic [4*NCORES-1:0] r_irq_o,   w_irq_o;
   logic [8*NCORES-1:0] r_cause_o, w_cause_o;
   logic [NCORES-1:0]   r_spur,    w_spur;
   logic [NCORES-1:0]   w_busy;

   // Capture decision
   int         w_tgt;
   logic       w_tgt_ok;
   logic       w_tgt_pv;
   logic [3:0] w_tgt_plvl;
   logic       w_attempt;
   logic       w_write;

`ifdef RF68000_IRQ_ROUTER_RR_EN
   logic [2:0] r_rr_ptr, w_rr_ptr;
   logic       w_found;
`endif

   // Input register stage: the controller tuple is sampled before any decision
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_in_irq   <= 4'd0;
         r_in_cause <= 8'd0;
         r_in_core  <= 6'd0;
      end else begin
         r_in_irq   <= bus.irq_i;
         r_in_cause <= bus.cause_i;
         r_in_core  <= bus.core_i;
      end
   end

   // Next state: EOI pops first, iack then works on the reduced depth and
   // empties the slot, and a capture finally lands in the updated slot
   always_comb begin
      for (int c = 0; c < NCORES; c++) begin
         w_pv[c]      = r_pv[c];
         w_plvl[c]    = r_plvl[c];
         w_pcause[c]  = r_pcause[c];
         w_alvl[c][0] = r_alvl[c][0];
         w_alvl[c][1] = r_alvl[c][1];
         w_sd[c]      = r_sd[c];
         w_atop[c]    = 4'd0;
      end
      w_cause_o  = r_cause_o;
      w_spur     = '0;
      w_irq_o    = '0;
      w_last     = r_last;
      w_tgt      = 0;
      w_tgt_ok   = 1'b0;
      w_tgt_pv   = 1'b1;
      w_tgt_plvl = 4'd0;
      w_attempt  = 1'b0;
      w_write    = 1'b0;
`ifdef RF68000_IRQ_ROUTER_RR_EN
      w_rr_ptr   = r_rr_ptr;
      w_found    = 1'b0;
`endif

      for (int c = 0; c < NCORES; c++) begin
         if (bus.eoi_i[c] && (r_sd[c] != 2'd0)) begin
            w_sd[c] = r_sd[c] - 2'd1;
         end
         if (bus.iack_i[c]) begin
            if (r_pv[c] && (w_sd[c] != 2'd2)) begin
               if (w_sd[c] == 2'd0) begin
                  w_alvl[c][0] = r_plvl[c];
               end else begin
                  w_alvl[c][1] = r_plvl[c];
               end
               w_sd[c]              = w_sd[c] + 2'd1;
               w_pv[c]              = 1'b0;
               w_cause_o[8*c +: 8]  = r_pcause[c];
            end else begin
               w_cause_o[8*c +: 8]  = SPURIOUS;
               w_spur[c]            = 1'b1;
            end
         end
      end

      // Target selection against the post-acknowledge pending state
      if (r_in_core < c_NCORES) begin
         w_tgt    = int'(r_in_core);
         w_tgt_ok = 1'b1;
      end else if (r_in_core == c_BCAST) begin
         w_tgt_ok = 1'b1;
`ifdef RF68000_IRQ_ROUTER_RR_EN
         w_tgt = int'(r_rr_ptr);
         for (int k = 0; k < NCORES; k++) begin
            for (int c = 0; c < NCORES; c++) begin
               if (!w_found && (c == ((int'(r_rr_ptr) + k) % NCORES)) && !w_pv[c]) begin
                  w_found = 1'b1;
                  w_tgt   = c;
               end
            end
         end
`else
         w_tgt = 0;
`endif
      end

      for (int c = 0; c < NCORES; c++) begin
         if (w_tgt_ok && (c == w_tgt)) begin
            w_tgt_pv   = w_pv[c];
            w_tgt_plvl = w_plvl[c];
         end
      end

      w_attempt = (r_in_irq != 4'd0) &&
                  (({r_in_irq, r_in_cause, r_in_core} != r_last) || (w_tgt_ok && !w_tgt_pv));
      w_write   = w_attempt && w_tgt_ok && (!w_tgt_pv || (r_in_irq > w_tgt_plvl));
      if (w_attempt) begin
         w_last = {r_in_irq, r_in_cause, r_in_core};
      end

      for (int c = 0; c < NCORES; c++) begin
         if (w_write && (c == w_tgt)) begin
            w_pv[c]     = 1'b1;
            w_plvl[c]   = r_in_irq;
            w_pcause[c] = r_in_cause;
         end
      end

`ifdef RF68000_IRQ_ROUTER_RR_EN
      if (w_write && (r_in_core == c_BCAST)) begin
         w_rr_ptr = ((w_tgt + 1) == NCORES) ? 3'd0 : 3'(w_tgt + 1);
      end
`endif

      // A pending level is presented only while it outranks the active level
      for (int c = 0; c < NCORES; c++) begin
         if (w_sd[c] == 2'd1) begin
            w_atop[c] = w_alvl[c][0];
         end else if (w_sd[c] == 2'd2) begin
            w_atop[c] = w_alvl[c][1];
         end
         if (w_pv[c] && (w_plvl[c] > w_atop[c])) begin
            w_irq_o[4*c +: 4] = w_plvl[c];
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int c = 0; c < NCORES; c++) begin
            r_pv[c]      <= 1'b0;
            r_plvl[c]    <= 4'd0;
            r_pcause[c]  <= 8'd0;
            r_alvl[c][0] <= 4'd0;
            r_alvl[c][1] <= 4'd0;
            r_sd[c]      <= 2'd0;
         end
         r_last    <= '0;
         r_irq_o   <= '0;
         r_cause_o <= '0;
         r_spur    <= '0;
`ifdef RF68000_IRQ_ROUTER_RR_EN
         r_rr_ptr  <= 3'd0;
`endif
      end else begin
         for (int c = 0; c < NCORES; c++) begin
            r_pv[c]      <= w_pv[c];
            r_plvl[c]    <= w_plvl[c];
            r_pcause[c]  <= w_pcause[c];
            r_alvl[c][0] <= w_alvl[c][0];
            r_alvl[c][1] <= w_alvl[c][1];
            r_sd[c]      <= w_sd[c];
         end
         r_last    <= w_last;
         r_irq_o   <= w_irq_o;
         r_cause_o <= w_cause_o;
         r_spur    <= w_spur;
`ifdef RF68000_IRQ_ROUTER_RR_EN
         r_rr_ptr  <= w_rr_ptr;
`endif
      end
   end

   // A core is busy while it holds any acknowledged, un-ended interrupt
   always_comb begin
      w_busy = '0;
      for (int c = 0; c < NCORES; c++) begin
         w_busy[c] = (r_sd[c] != 2'd0);
      end
   end

   assign bus.irq_o      = r_irq_o;
   assign bus.cause_o    = r_cause_o;
   assign bus.spurious_o = r_spur;
   assign bus.busy_o     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_rf68000_irq_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf68000_irq_router
//  Description : Directed self-checking bench for rf68000_irq_router (4 cores).
//                Expectations follow RF68000_IRQ_ROUTER_RR_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf68000_irq_router;
   logic clk;
   logic rst;
   int   tests;
   int   fails;

   rf68000_irq_router_if #(.NCORES(4)) bus ();

   rf68000_irq_router #(
      .NCORES   (4),
      .SPURIOUS (8'd24)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One-cycle request; returns once the slot and irq_o have updated
   task automatic req(input logic [3:0] lvl, input logic [7:0] cause, input logic [5:0] core);
      bus.irq_i   = lvl;
      bus.cause_i = cause;
      bus.core_i  = core;
      tick();
      bus.irq_i   = 4'd0;
      tick();
   endtask

   task automatic pulse(input logic [3:0] ack, input logic [3:0] eoi);
      bus.iack_i = ack;
      bus.eoi_i  = eoi;
      tick();
      bus.iack_i = 4'd0;
      bus.eoi_i  = 4'd0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.irq_i = 4'd0; bus.cause_i = 8'd0; bus.core_i = 6'd0;
      bus.iack_i = 4'd0; bus.eoi_i = 4'd0;
      tick();
      tick();
      check("rst_irq",   32'(bus.irq_o),      32'h0);
      check("rst_cause", bus.cause_o,          32'h0);
      check("rst_spur",  32'(bus.spurious_o), 32'h0);
      check("rst_busy",  32'(bus.busy_o),     32'h0);
      rst = 1'b0;
      tick();

      // Directed delivery to core 2
      req(4'd5, 8'h40, 6'd2);
      check("dir_irq",   32'(bus.irq_o), 32'h0500);
      pulse(4'b0100, 4'b0000);
      check("dir_cause", 32'(bus.cause_o[23:16]), 32'h40);
      check("dir_irq0",  32'(bus.irq_o),  32'h0);
      check("dir_busy",  32'(bus.busy_o), 32'b0100);
      pulse(4'b0000, 4'b0100);
      check("dir_eoi",   32'(bus.busy_o), 32'h0);

      // Preemption of a pending level on core 1
      req(4'd3, 8'h11, 6'd1);
      check("pre_irq3",  32'(bus.irq_o), 32'h0030);
      req(4'd6, 8'h50, 6'd1);
      check("pre_irq6",  32'(bus.irq_o), 32'h0060);
      pulse(4'b0010, 4'b0000);
      check("pre_cause", 32'(bus.cause_o[15:8]), 32'h50);
      check("pre_spur",  32'(bus.spurious_o), 32'h0);
      pulse(4'b0000, 4'b0010);
      check("pre_eoi",   32'(bus.busy_o), 32'h0);

      // Nesting on core 0
      req(4'd3, 8'h33, 6'd0);
      check("nest_irq3", 32'(bus.irq_o), 32'h0003);
      pulse(4'b0001, 4'b0000);
      check("nest_c33",  32'(bus.cause_o[7:0]), 32'h33);
      req(4'd6, 8'h66, 6'd0);
      check("nest_irq6", 32'(bus.irq_o), 32'h0006);
      pulse(4'b0001, 4'b0000);
      check("nest_c66",  32'(bus.cause_o[7:0]), 32'h66);
      check("nest_ir0",  32'(bus.irq_o), 32'h0);
      req(4'd7, 8'h77, 6'd0);
      check("nest_irq7", 32'(bus.irq_o), 32'h0007);
      pulse(4'b0001, 4'b0000);
      check("spur_cause", 32'(bus.cause_o[7:0]), 32'd24);
      check("spur_pulse", 32'(bus.spurious_o), 32'b0001);
      check("spur_irq",   32'(bus.irq_o), 32'h0007);
      tick();
      check("spur_clr",   32'(bus.spurious_o), 32'h0);
      // iack and eoi together at full depth
      pulse(4'b0001, 4'b0001);
      check("ie_cause", 32'(bus.cause_o[7:0]), 32'h77);
      check("ie_irq",   32'(bus.irq_o), 32'h0);
      check("ie_spur",  32'(bus.spurious_o), 32'h0);
      pulse(4'b0000, 4'b0001);
      check("ie_busy1", 32'(bus.busy_o), 32'b0001);
      pulse(4'b0000, 4'b0001);
      check("ie_busy0", 32'(bus.busy_o), 32'h0);

      // Masking by the active level
      req(4'd6, 8'h61, 6'd0);
      pulse(4'b0001, 4'b0000);
      check("mask_c61", 32'(bus.cause_o[7:0]), 32'h61);
      req(4'd4, 8'h44, 6'd0);
      check("mask_irq", 32'(bus.irq_o), 32'h0);
      tick();
      check("mask_hold", 32'(bus.irq_o), 32'h0);
      pulse(4'b0000, 4'b0001);
      check("mask_eoi", 32'(bus.irq_o), 32'h0004);
      pulse(4'b0001, 4'b0000);
      check("mask_c44", 32'(bus.cause_o[7:0]), 32'h44);
      pulse(4'b0000, 4'b0001);
      check("mask_busy", 32'(bus.busy_o), 32'h0);

      // Out-of-range target is ignored
      req(4'd5, 8'h55, 6'd5);
      check("ign_irq",   32'(bus.irq_o),  32'h0);
      check("ign_busy",  32'(bus.busy_o), 32'h0);
      check("ign_cause", bus.cause_o,     32'h00405044);

      // Broadcasts
      req(4'd1, 8'hB1, 6'h3F);
      check("bc_first", 32'(bus.irq_o), 32'h0001);
      req(4'd2, 8'hB2, 6'h3F);
      req(4'd3, 8'hB3, 6'h3F);
      req(4'd4, 8'hB4, 6'h3F);
`ifdef RF68000_IRQ_ROUTER_RR_EN
      check("bc_all",   32'(bus.irq_o), 32'h4321);
`else
      check("bc_all",   32'(bus.irq_o), 32'h0004);
`endif
      pulse(4'b0001, 4'b0000);
`ifdef RF68000_IRQ_ROUTER_RR_EN
      check("bc_cause", 32'(bus.cause_o[7:0]), 32'hB1);
      check("bc_irq",   32'(bus.irq_o), 32'h4320);
`else
      check("bc_cause", 32'(bus.cause_o[7:0]), 32'hB4);
      check("bc_irq",   32'(bus.irq_o), 32'h0000);
`endif
      check("bc_busy",  32'(bus.busy_o), 32'b0001);

      // Reset while active, with a request held by the controller
      rst = 1'b1;
      bus.irq_i = 4'd2; bus.cause_i = 8'h22; bus.core_i = 6'd3;
      tick();
      check("mrst_irq",   32'(bus.irq_o),      32'h0);
      check("mrst_cause", bus.cause_o,          32'h0);
      check("mrst_busy",  32'(bus.busy_o),     32'h0);
      check("mrst_spur",  32'(bus.spurious_o), 32'h0);
      rst = 1'b0;
      tick();
      check("recap_1", 32'(bus.irq_o), 32'h0);
      tick();
      check("recap_2", 32'(bus.irq_o), 32'h2000);
      bus.irq_i = 4'd0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
